// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the packed-BCD modulo counter.
// to_bcd folds at elaboration to build the wrap constant; bcd_valid checks digits.
// No ports: package only.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX     = 4'd9;
  localparam int         BCD_MAX_DIG = 4;

  // Widest supported word; narrower counters use the low 4*NDIG bits.
  typedef logic [4*BCD_MAX_DIG-1:0] bcd_word_t;

  // Binary integer to packed BCD, digit 0 in [3:0].
  function automatic bcd_word_t to_bcd(input int val);
    bcd_word_t r;
    int        v;
    r = '0;
    v = val;
    for (int i = 0; i < BCD_MAX_DIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  // True when every one of the low ndig digits is a legal decimal digit.
  function automatic logic bcd_valid(input bcd_word_t val, input int ndig);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIG; i++) begin
      if (i < ndig && val[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: combinational next-digit and carry/borrow.
// Ports: d (current digit), ci (step this decade), dn (0=up, 1=down), max_dig
// (top digit value), q (next digit), co (ci while d sits at max_dig up / 0 down).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       dn,
  input  logic [3:0] max_dig,
  output logic [3:0] q,
  output logic       co
);

  logic at_edge;

  assign at_edge = dn ? (d == 4'd0) : (d == max_dig);
  assign co      = ci & at_edge;

  always_comb begin
    q = d;
    if (ci) begin
      if (at_edge) q = dn ? max_dig : 4'd0;
      else         q = dn ? (d - 4'd1) : (d + 4'd1);
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Packed-BCD up/down counter over 0..MOD-1 across NDIG decades; CA chains to the next EN.
// Ports: CLK, RST (sync, high), EN, CLR, DN, LD, LD_VAL in; Q (registered), CA (comb), LD_ERR out.
// Optional load path enabled by macro BCD_MOD_CNT_LOAD_EN; otherwise LD/LD_VAL ignored, LD_ERR stays 0.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int MOD  = 60
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CLR,
  input  logic              DN,
  input  logic              LD,
  input  logic [4*NDIG-1:0] LD_VAL,
  output logic [4*NDIG-1:0] Q,
  output logic              CA,
  output logic              LD_ERR
);

  localparam int           W           = 4*NDIG;
  localparam bcd_word_t    MOD_M1_FULL = to_bcd(MOD - 1);
  localparam logic [W-1:0] MOD_M1      = MOD_M1_FULL[W-1:0];

  if (NDIG < 1 || NDIG > 4) begin : g_bad_ndig
    $error("bcd_mod_counter: NDIG=%0d outside 1..4", NDIG);
  end
  if (MOD < 2 || MOD > 10**NDIG) begin : g_bad_mod
    $error("bcd_mod_counter: MOD=%0d outside 2..10**NDIG", MOD);
  end

  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  cnt_step;
  logic [NDIG:0] c;
  logic          ld_err_q, ld_err_d;
  logic          at_top, at_zero, wrap;
  logic          ld_eff, ld_ok;

  // Plain decimal ripple; the modulo wrap below overrides it at MOD-1 / 0.
  assign c[0] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .d       (q_q[4*i +: 4]),
      .ci      (c[i]),
      .dn      (DN),
      .max_dig (BCD_MAX),
      .q       (cnt_step[4*i +: 4]),
      .co      (c[i+1])
    );
  end

  // Top-decade carry is subsumed by the wrap compare.
  logic unused_top_co;
  assign unused_top_co = c[NDIG];

  assign at_top  = (q_q == MOD_M1);
  assign at_zero = (q_q == '0);
  assign wrap    = DN ? at_zero : at_top;

`ifdef BCD_MOD_CNT_LOAD_EN
  assign ld_eff = LD;
  // Valid BCD preserves numeric order, so a plain compare against MOD-1 works.
  assign ld_ok  = bcd_valid(bcd_word_t'(LD_VAL), NDIG) && (LD_VAL <= MOD_M1);
`else
  assign ld_eff = 1'b0;
  assign ld_ok  = 1'b0;
  logic unused_ld;
  assign unused_ld = LD ^ (^LD_VAL);
`endif

  // Combinational so a cascaded stage advances on the same edge.
  assign CA = EN & ~CLR & ~ld_eff & wrap;

  always_comb begin
    q_d      = q_q;
    ld_err_d = 1'b0;
    if (CLR) begin
      q_d = '0;
    end else if (ld_eff) begin
      if (ld_ok) begin
        q_d = LD_VAL;
      end else begin
        q_d      = '0;
        ld_err_d = 1'b1;
      end
    end else if (EN) begin
      if (wrap) q_d = DN ? MOD_M1 : '0;
      else      q_d = cnt_step;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q      <= '0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign Q      = q_q;
  assign LD_ERR = ld_err_q;

  a_q_in_range: assert property (@(posedge CLK) disable iff (RST)
    bcd_valid(bcd_word_t'(q_q), NDIG) && (q_q <= MOD_M1));

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Randomized self-checking bench: MOD 60/24/100 counters on shared inputs plus a 60/60/24 cascade.
// Expected values come from integer-arithmetic models; directed literals pin the models.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_bcd_mod_counter;

`ifdef BCD_MOD_CNT_LOAD_EN
  localparam bit LD_ON = 1'b1;
`else
  localparam bit LD_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, EN, CLR, DN, LD;
  logic [7:0] LD_VAL;
  logic [7:0] q60, q24, q100;
  logic       ca60, ca24, ca100, e60, e24, e100;
  logic       cen, cdn;
  logic [7:0] qs, qm, qh;
  logic       cas, cam, cah, es, em, eh;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int m60 = 0, m24 = 0, m100 = 0, t = 0, ca_cnt = 0;
  bit x60 = 1'b0, x24 = 1'b0, x100 = 1'b0;

  always #5 CLK = ~CLK;

  bcd_mod_counter #(.NDIG(2), .MOD(60)) dut60 (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .DN(DN), .LD(LD), .LD_VAL(LD_VAL),
    .Q(q60), .CA(ca60), .LD_ERR(e60));
  bcd_mod_counter #(.NDIG(2), .MOD(24)) dut24 (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .DN(DN), .LD(LD), .LD_VAL(LD_VAL),
    .Q(q24), .CA(ca24), .LD_ERR(e24));
  bcd_mod_counter #(.NDIG(2), .MOD(100)) dut100 (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .DN(DN), .LD(LD), .LD_VAL(LD_VAL),
    .Q(q100), .CA(ca100), .LD_ERR(e100));

  bcd_mod_counter #(.NDIG(2), .MOD(60)) c_sec (
    .CLK(CLK), .RST(RST), .EN(cen), .CLR(1'b0), .DN(cdn), .LD(1'b0), .LD_VAL(8'h00),
    .Q(qs), .CA(cas), .LD_ERR(es));
  bcd_mod_counter #(.NDIG(2), .MOD(60)) c_min (
    .CLK(CLK), .RST(RST), .EN(cas), .CLR(1'b0), .DN(cdn), .LD(1'b0), .LD_VAL(8'h00),
    .Q(qm), .CA(cam), .LD_ERR(em));
  bcd_mod_counter #(.NDIG(2), .MOD(24)) c_hr (
    .CLK(CLK), .RST(RST), .EN(cam), .CLR(1'b0), .DN(cdn), .LD(1'b0), .LD_VAL(8'h00),
    .Q(qh), .CA(cah), .LD_ERR(eh));

  // ---------------- reference model (plain integers) ----------------
  function automatic logic [7:0] bcd8(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit ld_ok(input logic [7:0] lv, input int mod);
    return (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9) && (bcd_int(lv) < mod);
  endfunction

  function automatic int nxt(input int v, input int mod);
    if (RST || CLR) return 0;
    if (LD_ON && LD) return ld_ok(LD_VAL, mod) ? bcd_int(LD_VAL) : 0;
    if (!EN) return v;
    return DN ? (v + mod - 1) % mod : (v + 1) % mod;
  endfunction

  function automatic bit nerr(input int mod);
    return !RST && !CLR && LD_ON && LD && !ld_ok(LD_VAL, mod);
  endfunction

  function automatic bit eca(input int v, input int mod);
    return EN && !CLR && !(LD_ON && LD) && (DN ? (v == 0) : (v == mod - 1));
  endfunction

  always @(posedge CLK) begin
    x60  = nerr(60);  m60  = nxt(m60, 60);
    x24  = nerr(24);  m24  = nxt(m24, 24);
    x100 = nerr(100); m100 = nxt(m100, 100);
    if (RST)      t = 0;
    else if (cen) t = cdn ? (t + 86399) % 86400 : (t + 1) % 86400;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("q60",    32'(q60),   32'(bcd8(m60)));
      chk("ca60",   32'(ca60),  32'(eca(m60, 60)));
      chk("err60",  32'(e60),   32'(x60));
      chk("q24",    32'(q24),   32'(bcd8(m24)));
      chk("ca24",   32'(ca24),  32'(eca(m24, 24)));
      chk("err24",  32'(e24),   32'(x24));
      chk("q100",   32'(q100),  32'(bcd8(m100)));
      chk("ca100",  32'(ca100), 32'(eca(m100, 100)));
      chk("err100", 32'(e100),  32'(x100));
      chk("c_sec",  32'(qs),    32'(bcd8(t % 60)));
      chk("c_min",  32'(qm),    32'(bcd8((t / 60) % 60)));
      chk("c_hr",   32'(qh),    32'(bcd8(t / 3600)));
      chk("c_top_ca", 32'(cah), 32'(cen && (cdn ? (t == 0) : (t == 86399))));
      chk("c_err",  32'({es, em, eh}), 32'd0);
    end
  end

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; EN = 1'b1; CLR = 1'b0; DN = 1'b0; LD = 1'b0; LD_VAL = 8'h00;
    cen = 1'b0; cdn = 1'b0;
    edge_(); edge_();
    chk_on = 1'b1;
    at_neg();
    chk("rst_q",   32'(q60),  32'h00);
    chk("rst_ca",  32'(ca60), 32'h0);
    chk("rst_err", 32'(e60),  32'h0);
    edge_();
    RST = 1'b0; EN = 1'b1; DN = 1'b0;

    // Up through a full 60-count cycle.
    ca_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      at_neg();
      if (ca60) ca_cnt++;
      if (i == 9)  chk("up_09", 32'(q60), 32'h09);
      if (i == 10) chk("up_10", 32'(q60), 32'h10);
      if (i == 59) begin
        chk("up_59",    32'(q60),  32'h59);
        chk("up_ca_59", 32'(ca60), 32'h1);
      end
      edge_();
    end
    chk("ca_once", 32'(ca_cnt), 32'd1);

    // Down: borrow out of 00, then decade borrow 50 -> 49.
    DN = 1'b1;
    at_neg();
    chk("wrap_00",  32'(q60),  32'h00);
    chk("dn_ca_00", 32'(ca60), 32'h1);
    edge_();
    at_neg();
    chk("dn_59", 32'(q60), 32'h59);
    for (int i = 0; i < 9; i++) edge_();
    at_neg();
    chk("dn_50", 32'(q60), 32'h50);
    edge_();
    DN = 1'b0;
    at_neg();
    chk("dn_49", 32'(q60), 32'h49);

    // CLR beats EN at 59; RST mid-count.
    for (int i = 0; i < 10; i++) edge_();
    CLR = 1'b1;
    at_neg();
    chk("clr_at_59", 32'(q60),  32'h59);
    chk("clr_no_ca", 32'(ca60), 32'h0);
    edge_();
    CLR = 1'b0;
    at_neg();
    chk("clr_q", 32'(q60), 32'h00);
    for (int i = 0; i < 37; i++) edge_();
    RST = 1'b1;
    at_neg();
    chk("pre_rst_37", 32'(q60), 32'h37);
    edge_();
    RST = 1'b0;
    at_neg();
    chk("mid_rst_q", 32'(q60), 32'h00);

    // Modulus-24 wrap, then modulus-100 natural 99 -> 00.
    for (int i = 0; i < 23; i++) edge_();
    at_neg();
    chk("m24_23", 32'(q24),  32'h23);
    chk("m24_ca", 32'(ca24), 32'h1);
    edge_();
    at_neg();
    chk("m24_wrap", 32'(q24), 32'h00);
    for (int i = 0; i < 75; i++) edge_();
    at_neg();
    chk("m100_99", 32'(q100),  32'h99);
    chk("m100_ca", 32'(ca100), 32'h1);
    edge_();
    at_neg();
    chk("m100_wrap", 32'(q100), 32'h00);

    // Load path.
    edge_();
    RST = 1'b1;
    edge_();
    RST = 1'b0;
`ifdef BCD_MOD_CNT_LOAD_EN
    EN = 1'b0; LD = 1'b1; LD_VAL = 8'h42;
    edge_();
    LD = 1'b0;
    at_neg();
    chk("ld_42",     32'(q60), 32'h42);
    chk("ld_42_err", 32'(e60), 32'h0);
    edge_();
    EN = 1'b1; LD = 1'b1; LD_VAL = 8'h61;
    edge_();
    EN = 1'b0; LD = 1'b0;
    at_neg();
    chk("ld_61_q",   32'(q60), 32'h00);
    chk("ld_61_err", 32'(e60), 32'h1);
    edge_();
    at_neg();
    chk("ld_err_pulse", 32'(e60), 32'h0);
    LD = 1'b0;
    edge_();
    LD = 1'b1; LD_VAL = 8'h3A;
    edge_();
    LD = 1'b0;
    at_neg();
    chk("ld_3a_q",   32'(q60), 32'h00);
    chk("ld_3a_err", 32'(e60), 32'h1);
    edge_();
`else
    EN = 1'b1; LD = 1'b1; LD_VAL = 8'h42;
    edge_();
    LD = 1'b0;
    at_neg();
    chk("ld_ignored",     32'(q60), 32'h01);
    chk("ld_ignored_err", 32'(e60), 32'h0);
    edge_();
`endif

    // Cascade 60/60/24: borrow out of 00:00:00 and carry back.
    RST = 1'b1; EN = 1'b0;
    edge_();
    RST = 1'b0; cen = 1'b1; cdn = 1'b1;
    at_neg();
    chk("casc_dn_ca", 32'(cah), 32'h1);
    edge_();
    cen = 1'b0;
    at_neg();
    chk("casc_hr_23", 32'(qh), 32'h23);
    chk("casc_mn_59", 32'(qm), 32'h59);
    chk("casc_sc_59", 32'(qs), 32'h59);
    edge_();
    cen = 1'b1; cdn = 1'b0;
    at_neg();
    chk("casc_up_ca", 32'(cah), 32'h1);
    edge_();
    cen = 1'b0;
    at_neg();
    chk("casc_hr_00", 32'(qh), 32'h00);
    chk("casc_sc_00", 32'(qs), 32'h00);
    edge_();

    // Random traffic on every input.
    for (int n = 0; n < 3000; n++) begin
      RST    = ($urandom_range(0, 199) == 0);
      EN     = ($urandom_range(0, 3) != 0);
      CLR    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) DN = ~DN;
      LD     = ($urandom_range(0, 15) == 0);
      LD_VAL = 8'($urandom_range(0, 255));
      cen    = ($urandom_range(0, 3) != 0);
      cdn    = ($urandom_range(0, 7) == 0);
      edge_();
    end

    // Long cascade run up through minute and hour carries.
    RST = 1'b0; CLR = 1'b0; LD = 1'b0; cdn = 1'b0; cen = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      EN = ($urandom_range(0, 1) != 0);
      DN = ($urandom_range(0, 3) == 0);
      edge_();
    end
    at_neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
